glitc_clock_edge_scanner: RTL and testbench
===========================================

Name: glitc_clock_edge_scanner

Overview:
Multi-channel successor to the single-channel clock-path delay load. For each enabled channel it sweeps the 5-bit input-delay tap over its full range and samples the delayed clock at each tap to find the 0->1 edge. It then programs a final delay of edge tap + offset. It sits in the clk_i domain beside the per-channel clock-path wrappers and drives their delay and load inputs.

Parameters:
NUM_CH, 4, number of clock-path channels scanned.
TAP_BITS, 5, width of one delay tap value; max tap = 2^TAP_BITS-1.
SETTLE_CYCLES, 16, clk_i cycles waited after each load before sampling (>=1).
SAMPLE_LOG2, 4, log2 of samples taken per tap (16 samples).
EDGE_OFFSET, 8, taps added to the found edge for the final delay.

Ports:
clk_i  input  1  system clock; the only clock.
rst_n_i  input  1  asynchronous, active-low reset.
start_i  input  1  one-cycle request to begin a scan; ignored while busy_o=1.
ch_mask_i  input  NUM_CH  1 = scan channel; sampled at the start_i cycle.
sample_i  input  NUM_CH  delayed-clock sample per channel; already synchronised into clk_i by the caller.
delay_o  output  NUM_CH*TAP_BITS  tap value per channel; channel k occupies bits [k*TAP_BITS +: TAP_BITS].
load_o  output  NUM_CH  one-cycle load strobe per channel.
busy_o  output  1  high from the cycle after start_i until done_o.
done_o  output  1  one-cycle pulse at scan end.
found_o  output  NUM_CH  edge found on the last scan.
edge_tap_o  output  NUM_CH*TAP_BITS  tap at which the edge was found; 0 if not found.

Behaviour:
- Reset, asynchronous: all outputs 0, FSM in IDLE, all counters 0. Asserting reset mid-scan aborts immediately; no load_o is issued on release.
- Channels are scanned sequentially, lowest index first. One shared tap counter, settle counter and sample counter serve all channels.
- FSM states: IDLE, NEXT_CH, LOAD, SETTLE, SAMPLE, EVAL, FINAL, DONE.
- IDLE, on start_i: latch the mask, set ch=0, clear prev_bit, clear found_o and edge_tap_o for masked-in channels, go to NEXT_CH.
- NEXT_CH: if ch==NUM_CH, go to DONE. Else if mask[ch]=0, ch++ (one cycle per skipped channel); that channel's delay_o, found_o and edge_tap_o are left untouched. Else set tap=0 and go to LOAD.
- LOAD: delay_o[ch]=tap, load_o[ch]=1 for exactly this cycle. Go to SETTLE.
- SETTLE: wait SETTLE_CYCLES cycles, then go to SAMPLE.
- SAMPLE: for 2^SAMPLE_LOG2 cycles, add sample_i[ch] to a ones counter of SAMPLE_LOG2+1 bits. The counter cannot overflow.
- EVAL: bit = (ones > 2^(SAMPLE_LOG2-1)), so a tie counts as 0.
  - If tap>0, prev_bit==0 and bit==1: edge at this tap. Set found_o[ch]=1, edge_tap_o[ch]=tap, go to FINAL.
  - Else if tap==max: set found_o[ch]=0, edge_tap_o[ch]=0, go to FINAL.
  - Else prev_bit=bit, tap++, go to LOAD.
- Tap 0 never qualifies as an edge, even if its sample is 1.
- FINAL:
  - If found: delay_o[ch]=min(edge+EDGE_OFFSET, max), computed at TAP_BITS+1 width and saturated.
  - If not found: delay_o[ch]=0.
  - Either way load_o[ch]=1 for one cycle. Then ch++, prev_bit=0, go to NEXT_CH.
- DONE: done_o=1 for one cycle, busy_o drops in the same cycle, return to IDLE.
- Per-tap latency: 1 (LOAD) + SETTLE_CYCLES + 2^SAMPLE_LOG2 + 1 (EVAL); 34 cycles with defaults.
- Only one bit of load_o is ever high, and never for more than one consecutive cycle.
- delay_o[ch] is stable at least SETTLE_CYCLES cycles before any sample is counted.
- start_i coincident with done_o is ignored.
- If start_i arrives with mask=0, the FSM passes through NEXT_CH NUM_CH+1 times, then DONE, with no load_o.

Test Plan:
- Reset mid-scan: assert rst_n_i low during SAMPLE on ch1 -> all outputs 0 immediately; after release, no load_o until the next start_i.
- Single channel, mask=4'b0001, sample_i[0]=1 iff tap>=10 -> load_o[0] pulses at taps 0..10 every 34 cycles, then a final pulse; found_o[0]=1, edge_tap_o[0]=10, delay_o[0]=18, done_o pulses once.
- Saturation: edge at tap 28 -> delay_o=31. No edge (sample_i always 0) -> 32 tap loads plus a final load, found_o=0, delay_o=0.
- Tap-0 high and tie rule:
  - sample_i=1 for all taps -> found_o=0.
  - At one tap, exactly 8 of 16 samples are 1 -> that tap is treated as 0, so no edge is reported there.
- mask=4'b1010 with edges at taps 5 and 20 -> channels 0 and 2 untouched (prior delay_o kept); ch1 delay_o=13, ch3 delay_o=28; load_o never has two bits set.
- start_i held high through the scan and at done_o -> exactly one scan runs; mask=0 start gives a done_o pulse with no load_o.

Source files
------------

// File: rtl/glitc_clock_edge_scanner.sv
// Multi-channel clock edge scanner.
// Scans the enabled channels one after another, lowest index first. For each
// channel the input-delay tap is swept upward from 0. At each tap the scanner
// loads the tap, lets the delay line settle, and takes a majority vote over
// 2^SAMPLE_LOG2 samples. The first tap above 0 whose vote is 1, when the tap
// before it voted 0, is the 0->1 edge. The scanner then loads a final delay of
// edge + EDGE_OFFSET, saturated at the largest tap, or 0 if no edge was found.
//
// Handshake: a start_i pulse is accepted only in IDLE, where busy_o is low.
// busy_o stays high until the cycle in which done_o pulses. load_o carries
// one-cycle strobes to the per-channel clock-path wrappers, and the matching
// delay_o slice is already valid in the strobe cycle.
// The FSM state is kept in the 'state' signal so checkers can bind to it.
module glitc_clock_edge_scanner #(
  parameter int NUM_CH        = 4,
  parameter int TAP_BITS      = 5,
  parameter int SETTLE_CYCLES = 16,
  parameter int SAMPLE_LOG2   = 4,
  parameter int EDGE_OFFSET   = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         start_i,
  input  logic [NUM_CH-1:0]            ch_mask_i,
  input  logic [NUM_CH-1:0]            sample_i,
  output logic [NUM_CH*TAP_BITS-1:0]   delay_o,
  output logic [NUM_CH-1:0]            load_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [NUM_CH-1:0]            found_o,
  output logic [NUM_CH*TAP_BITS-1:0]   edge_tap_o
);

  localparam int CH_W  = $clog2(NUM_CH + 1);
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [CH_W-1:0]        CH_END   = CH_W'(NUM_CH);
  localparam logic [SET_W-1:0]       SET_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [SAMPLE_LOG2:0]   TIE      = (SAMPLE_LOG2 + 1)'(1 << (SAMPLE_LOG2 - 1));
  localparam logic [TAP_BITS:0]      OFFSET_W = (TAP_BITS + 1)'(EDGE_OFFSET);

  typedef enum logic [2:0] {
    IDLE, NEXT_CH, LOAD, SETTLE, SAMPLE, EVAL, FINAL, DONE
  } state_t;

  state_t                   state;
  logic [NUM_CH-1:0]        mask;
  logic [CH_W-1:0]          ch;
  logic [TAP_BITS-1:0]      tap;
  logic [SET_W-1:0]         settle_cnt;
  logic [SAMPLE_LOG2-1:0]   sample_cnt;
  logic [SAMPLE_LOG2:0]     ones;
  logic                     prev_bit;
  logic [TAP_BITS-1:0]      delay_r [NUM_CH];
  logic [TAP_BITS-1:0]      edge_r  [NUM_CH];

  logic [SEL_W-1:0]         ch_sel;
  logic                     cur_bit;
  logic [TAP_BITS:0]        final_sum;
  logic [TAP_BITS-1:0]      final_dly;

  // Channel index, majority vote (a tie counts as 0) and saturated final delay.
  assign ch_sel    = ch[SEL_W-1:0];
  assign cur_bit   = (ones > TIE);
  assign final_sum = {1'b0, tap} + OFFSET_W;
  assign final_dly = final_sum[TAP_BITS] ? '1 : final_sum[TAP_BITS-1:0];

  // Pack the per-channel registers onto the flat output buses.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_pack
    assign delay_o[k*TAP_BITS +: TAP_BITS]    = delay_r[k];
    assign edge_tap_o[k*TAP_BITS +: TAP_BITS] = edge_r[k];
  end

  // Scan FSM. Every output is a register. Strobes are set on the transition
  // into the state that owns them, so they are high exactly in that state.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= IDLE;
      mask       <= '0;
      ch         <= '0;
      tap        <= '0;
      settle_cnt <= '0;
      sample_cnt <= '0;
      ones       <= '0;
      prev_bit   <= 1'b0;
      load_o     <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      found_o    <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        delay_r[k] <= '0;
        edge_r[k]  <= '0;
      end
    end else begin
      load_o <= '0;
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            mask     <= ch_mask_i;
            ch       <= '0;
            prev_bit <= 1'b0;
            busy_o   <= 1'b1;
            found_o  <= found_o & ~ch_mask_i;
            for (int k = 0; k < NUM_CH; k++) begin
              if (ch_mask_i[k]) edge_r[k] <= '0;
            end
            state <= NEXT_CH;
          end
        end
        NEXT_CH: begin
          if (ch == CH_END) begin
            done_o <= 1'b1;
            busy_o <= 1'b0;
            state  <= DONE;
          end else if (!mask[ch_sel]) begin
            ch <= ch + CH_W'(1);
          end else begin
            tap              <= '0;
            delay_r[ch_sel]  <= '0;
            load_o[ch_sel]   <= 1'b1;
            state            <= LOAD;
          end
        end
        LOAD: begin
          settle_cnt <= '0;
          state      <= SETTLE;
        end
        SETTLE: begin
          if (settle_cnt == SET_LAST) begin
            sample_cnt <= '0;
            ones       <= '0;
            state      <= SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + SET_W'(1);
          end
        end
        SAMPLE: begin
          ones       <= ones + {{SAMPLE_LOG2{1'b0}}, sample_i[ch_sel]};
          sample_cnt <= sample_cnt + SAMPLE_LOG2'(1);
          if (sample_cnt == '1) state <= EVAL;
        end
        EVAL: begin
          if ((tap != '0) && !prev_bit && cur_bit) begin
            found_o[ch_sel] <= 1'b1;
            edge_r[ch_sel]  <= tap;
            delay_r[ch_sel] <= final_dly;
            load_o[ch_sel]  <= 1'b1;
            state           <= FINAL;
          end else if (tap == '1) begin
            found_o[ch_sel] <= 1'b0;
            edge_r[ch_sel]  <= '0;
            delay_r[ch_sel] <= '0;
            load_o[ch_sel]  <= 1'b1;
            state           <= FINAL;
          end else begin
            prev_bit        <= cur_bit;
            tap             <= tap + TAP_BITS'(1);
            delay_r[ch_sel] <= tap + TAP_BITS'(1);
            load_o[ch_sel]  <= 1'b1;
            state           <= LOAD;
          end
        end
        FINAL: begin
          ch       <= ch + CH_W'(1);
          prev_bit <= 1'b0;
          state    <= NEXT_CH;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_glitc_clock_edge_scanner.sv
// Directed bench for glitc_clock_edge_scanner. A small delay-line model
// drives sample_i from each channel's delay_o. A negedge monitor counts
// load/done strobes and flags protocol violations.
module tb_glitc_clock_edge_scanner;

  localparam int NCH = 4;
  localparam int TB  = 5;

  // Clock and reset.
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic              start;
  logic [NCH-1:0]    ch_mask;
  logic [NCH-1:0]    sample;
  logic [NCH*TB-1:0] delay_o;
  logic [NCH-1:0]    load_o;
  logic              busy_o;
  logic              done_o;
  logic [NCH-1:0]    found_o;
  logic [NCH*TB-1:0] edge_tap_o;

  glitc_clock_edge_scanner dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .start_i    (start),
    .ch_mask_i  (ch_mask),
    .sample_i   (sample),
    .delay_o    (delay_o),
    .load_o     (load_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .found_o    (found_o),
    .edge_tap_o (edge_tap_o)
  );

  // Delay-line model. mode: 0 = 1 when tap >= edg, 1 = always 0, 2 = always 1,
  // 3 = like 0, but the tap just below edg toggles every cycle (8 of 16 ones).
  logic [1:0]    mode [NCH];
  logic [TB-1:0] edg  [NCH];
  logic          tog = 1'b0;
  always @(posedge clk) tog <= ~tog;

  always_comb begin
    sample = '0;
    for (int k = 0; k < NCH; k++) begin
      case (mode[k])
        2'd0: sample[k] = (delay_o[k*TB +: TB] >= edg[k]);
        2'd1: sample[k] = 1'b0;
        2'd2: sample[k] = 1'b1;
        default: sample[k] = (delay_o[k*TB +: TB] >= edg[k]) ? 1'b1 :
                             ((delay_o[k*TB +: TB] == edg[k] - 5'd1) ? tog : 1'b0);
      endcase
    end
  end

  // Monitor: strobe counters and protocol violation counters.
  int load_cnt [NCH] = '{default: 0};
  int done_cnt = 0;
  int cyc = 0;
  int viol_multi = 0;
  int viol_consec = 0;
  int viol_donebusy = 0;
  int q0[$];
  logic [NCH-1:0] prev_load = '0;
  always @(negedge clk) begin
    cyc++;
    if (!$onehot0(load_o)) viol_multi++;
    for (int k = 0; k < NCH; k++) begin
      if (load_o[k]) begin
        load_cnt[k]++;
        if (prev_load[k]) viol_consec++;
      end
    end
    if (load_o[0]) q0.push_back(cyc);
    if (done_o) begin
      done_cnt++;
      if (busy_o) viol_donebusy++;
    end
    prev_load = load_o;
  end

  // Scoreboard counters and comparison task.
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int total_loads();
    int s;
    s = 0;
    for (int k = 0; k < NCH; k++) s += load_cnt[k];
    return s;
  endfunction

  function automatic logic [TB-1:0] dly(input int k);
    return delay_o[k*TB +: TB];
  endfunction

  function automatic logic [TB-1:0] etap(input int k);
    return edge_tap_o[k*TB +: TB];
  endfunction

  // Driver: start a scan and wait for done_o under a cycle budget.
  // With hold=1, start_i stays high through the scan and the done_o cycle.
  task automatic run_scan(input string tag, input logic [NCH-1:0] m, input bit hold,
                          output int cycles);
    bit got;
    got = 1'b0;
    cycles = 0;
    @(negedge clk);
    ch_mask = m;
    start = 1'b1;
    for (int i = 0; i < 6000 && !got; i++) begin
      @(negedge clk);
      cycles++;
      // The mask must have been latched; scramble the input afterwards.
      ch_mask = 4'($urandom_range(0, 15));
      if (!hold) start = 1'b0;
      if (done_o) got = 1'b1;
    end
    if (hold) begin
      @(posedge clk);
      #1 start = 1'b0;
    end
    chk({tag, "_done_seen"}, 32'(got), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  int n, b0, b1, b2, b3, bd, bq, bad, bt;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    ch_mask = '0;
    for (int k = 0; k < NCH; k++) begin
      mode[k] = 2'd0;
      edg[k]  = 5'd31;
    end

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_load", 32'(load_o), 32'd0);
    chk("rst_found", 32'(found_o), 32'd0);
    chk("rst_delay", 32'(delay_o), 32'd0);
    chk("rst_edge", 32'(edge_tap_o), 32'd0);
    rst_n = 1'b1;

    // Reset in the middle of sampling on channel 1.
    edg[0] = 5'd2;
    edg[1] = 5'd5;
    @(negedge clk);
    ch_mask = 4'b0011;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!load_o[1] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("midrst_ch1_load_seen", 32'(load_o[1]), 32'd1);
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ctrl_zero", 32'({busy_o, done_o, load_o, found_o}), 32'd0);
    chk("midrst_delay_zero", 32'(delay_o), 32'd0);
    chk("midrst_edge_zero", 32'(edge_tap_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bt = total_loads();
    repeat (80) @(negedge clk);
    chk("midrst_no_load_after", 32'(total_loads() - bt), 32'd0);
    chk("midrst_idle", 32'(busy_o), 32'd0);

    // Single channel, edge at tap 10 -> delay 18.
    edg[0] = 5'd10;
    b0 = load_cnt[0]; bd = done_cnt; bq = q0.size();
    run_scan("edge10", 4'b0001, 1'b0, n);
    chk("edge10_loads", 32'(load_cnt[0] - b0), 32'd12);
    chk("edge10_found", 32'(found_o), 32'b0001);
    chk("edge10_edge_tap", 32'(etap(0)), 32'd10);
    chk("edge10_delay", 32'(dly(0)), 32'd18);
    chk("edge10_done_pulses", 32'(done_cnt - bd), 32'd1);
    bad = 0;
    if (q0.size() >= bq + 12) begin
      for (int i = bq + 1; i < bq + 12; i++) if (q0[i] - q0[i-1] != 34) bad++;
    end else begin
      bad = 99;
    end
    chk("edge10_load_spacing", 32'(bad), 32'd0);

    // Edge at tap 28 saturates the final delay to 31.
    edg[0] = 5'd28;
    b0 = load_cnt[0];
    run_scan("edge28", 4'b0001, 1'b0, n);
    chk("edge28_loads", 32'(load_cnt[0] - b0), 32'd30);
    chk("edge28_found", 32'(found_o), 32'b0001);
    chk("edge28_edge_tap", 32'(etap(0)), 32'd28);
    chk("edge28_delay_sat", 32'(dly(0)), 32'd31);

    // No edge: samples always 0.
    mode[0] = 2'd1;
    b0 = load_cnt[0];
    run_scan("noedge", 4'b0001, 1'b0, n);
    chk("noedge_loads", 32'(load_cnt[0] - b0), 32'd33);
    chk("noedge_found", 32'(found_o), 32'd0);
    chk("noedge_delay", 32'(dly(0)), 32'd0);
    chk("noedge_edge_tap", 32'(etap(0)), 32'd0);

    // Samples always 1: tap 0 never qualifies, so no edge.
    mode[0] = 2'd2;
    b0 = load_cnt[0];
    run_scan("allone", 4'b0001, 1'b0, n);
    chk("allone_loads", 32'(load_cnt[0] - b0), 32'd33);
    chk("allone_found", 32'(found_o), 32'd0);
    chk("allone_delay", 32'(dly(0)), 32'd0);

    // Tie at tap 6 counts as 0, so the edge is at 7 (ch0). Plain edge 3 on ch2.
    mode[0] = 2'd3; edg[0] = 5'd7;
    mode[2] = 2'd0; edg[2] = 5'd3;
    b0 = load_cnt[0]; b2 = load_cnt[2];
    run_scan("tie", 4'b0101, 1'b0, n);
    chk("tie_ch0_edge_tap", 32'(etap(0)), 32'd7);
    chk("tie_ch0_delay", 32'(dly(0)), 32'd15);
    chk("tie_ch2_delay", 32'(dly(2)), 32'd11);
    chk("tie_found", 32'(found_o), 32'b0101);
    chk("tie_loads", 32'(load_cnt[0] - b0 + load_cnt[2] - b2), 32'd9 + 32'd5);

    // mask 1010: channels 0 and 2 keep their previous results.
    mode[1] = 2'd0; edg[1] = 5'd5;
    mode[3] = 2'd0; edg[3] = 5'd20;
    b0 = load_cnt[0]; b1 = load_cnt[1]; b2 = load_cnt[2]; b3 = load_cnt[3];
    run_scan("m1010", 4'b1010, 1'b0, n);
    chk("m1010_delay", 32'(delay_o), 32'({5'd28, 5'd11, 5'd13, 5'd15}));
    chk("m1010_edge_tap", 32'(edge_tap_o), 32'({5'd20, 5'd3, 5'd5, 5'd7}));
    chk("m1010_found", 32'(found_o), 32'b1111);
    chk("m1010_skipped_loads", 32'(load_cnt[0] - b0 + load_cnt[2] - b2), 32'd0);
    chk("m1010_active_loads", 32'(load_cnt[1] - b1 + load_cnt[3] - b3), 32'd7 + 32'd22);
    chk("load_onehot", 32'(viol_multi), 32'd0);
    chk("load_single_cycle", 32'(viol_consec), 32'd0);

    // start_i held high through the scan and during done_o: one scan only.
    mode[0] = 2'd0; edg[0] = 5'd2;
    b0 = load_cnt[0]; bd = done_cnt;
    run_scan("hold", 4'b0001, 1'b1, n);
    repeat (100) @(negedge clk);
    chk("hold_done_pulses", 32'(done_cnt - bd), 32'd1);
    chk("hold_loads", 32'(load_cnt[0] - b0), 32'd4);
    chk("hold_idle", 32'(busy_o), 32'd0);
    chk("hold_delay", 32'(dly(0)), 32'd10);

    // Empty mask: five NEXT_CH cycles, then done with no loads.
    bt = total_loads(); bd = done_cnt;
    run_scan("mask0", 4'b0000, 1'b0, n);
    chk("mask0_done_latency", 32'(n), 32'd6);
    chk("mask0_no_loads", 32'(total_loads() - bt), 32'd0);
    chk("mask0_done_pulses", 32'(done_cnt - bd), 32'd1);
    chk("done_busy_exclusive", 32'(viol_donebusy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
